mxint_exp_scheduler: RTL
========================

Name: mxint_exp_scheduler

Overview:
- Shares one fixed-latency mxint exponential datapath between two block-stream requesters, e.g. two attention heads feeding softmax.
- Arbitrates round-robin and issues at most one MXINT block per cycle into the datapath.
- Tracks in-flight blocks with a tag pipeline and steers each result block to a per-requester output FIFO.
- Output FIFOs are credit-protected, so the non-stallable datapath never overflows them.

Parameters:
- DATA_IN_MAN_WIDTH, 8, input mantissa width per element
- DATA_IN_EXP_WIDTH, 3, shared input exponent width
- DATA_OUT_MAN_WIDTH, 10, result mantissa width per element
- DATA_OUT_EXP_WIDTH, 4, result exponent width per element
- BLOCK_SIZE, 16, elements per block
- EXP_LATENCY, 2, cycles from issue to result; must be at least 1
- FIFO_DEPTH, 4, result FIFO entries per requester; must be at least 1; full throughput needs at least EXP_LATENCY+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mdata_in_k  in  DATA_IN_MAN_WIDTH x BLOCK_SIZE  requester k mantissas (k = 0,1)
- edata_in_k  in  DATA_IN_EXP_WIDTH  requester k shared exponent
- data_in_k_valid  in  1  requester k valid
- data_in_k_ready  out  1  requester k ready
- ex_mdata_out  out  DATA_IN_MAN_WIDTH x BLOCK_SIZE  mantissas issued to the datapath
- ex_edata_out  out  DATA_IN_EXP_WIDTH  exponent issued to the datapath
- ex_valid_out  out  1  issue strobe
- ex_mdata_in  in  DATA_OUT_MAN_WIDTH x BLOCK_SIZE  result mantissas from the datapath
- ex_edata_in  in  DATA_OUT_EXP_WIDTH x BLOCK_SIZE  result exponents from the datapath
- ex_valid_in  in  1  result strobe
- mdata_out_k  out  DATA_OUT_MAN_WIDTH x BLOCK_SIZE  result mantissas for requester k
- edata_out_k  out  DATA_OUT_EXP_WIDTH x BLOCK_SIZE  result exponents for requester k
- data_out_k_valid  out  1  requester k result valid
- data_out_k_ready  in  1  requester k result ready
- busy  out  1  any block in flight or any FIFO non-empty
- err_sync  out  1  sticky: ex_valid_in disagreed with the tag pipeline

Behaviour:
- Clocking and reset
  - Single clock. rst is synchronous and active-high.
  - On reset: FIFOs empty, in-flight counters 0, tag pipeline cleared, RR pointer = 0, err_sync = 0.
  - All outputs are 0 during and immediately after reset (valids, readys, ex_valid_out, busy).
  - The datapath shares rst, so no stale results arrive after reset.
- Credits
  - credit_k = FIFO_DEPTH - occupancy_k - inflight_k, recomputed every cycle from registered state.
  - Requester k is eligible when data_in_k_valid = 1 and credit_k > 0.
- Arbitration
  - If both are eligible, grant the RR pointer side; otherwise grant the single eligible side.
  - On a grant, the pointer moves to the other requester. With no grant, the pointer holds.
  - data_in_k_ready = grant_k, combinational, at most one asserted per cycle.
  - ex_valid_out = any grant. ex_*_out is a combinational mux of the granted requester, all zeros when idle.
- Tag pipeline
  - A shift register EXP_LATENCY deep holds {valid, id}.
  - Stage 0 loads {grant, granted id} each cycle.
  - The tail is compared with ex_valid_in. On mismatch err_sync sets and stays set until reset, and the result is dropped.
  - On a match with tail valid, the result pushes into FIFO[id].
- Latency
  - A grant at edge t produces a result push at edge t+EXP_LATENCY.
  - data_out_k_valid rises the next cycle, giving a minimum of EXP_LATENCY+1 cycles from grant to output.
- FIFO accounting
  - Each FIFO is first-word-fall-through: data_out_k_valid = not empty, and the head is presented.
  - A pop occurs on valid & ready.
  - inflight_k increments on a grant and decrements on a push; both in one cycle leaves it unchanged.
  - A push and a pop in one cycle leave occupancy unchanged.
  - Credits guarantee a push never hits a full FIFO.
  - Read/write pointers wrap modulo FIFO_DEPTH, which need not be a power of two.
- Ordering and independence
  - Results are delivered in issue order per requester.
  - Requesters are independent: a stalled output k never blocks requester j.
- busy = OR of (inflight_k != 0) and (occupancy_k != 0).

Test Plan:
- Both requesters valid continuously, outputs always ready, EXP_LATENCY=2:
  - grants alternate 0,1,0,1 starting with 0;
  - first data_out_0_valid appears 3 cycles after the first grant;
  - each output then delivers 1 block every 2 cycles, in order (tag blocks with incrementing edata).
- Only requester 1 valid:
  - granted every cycle, 100% issue rate;
  - RR pointer is irrelevant and never starves requester 1.
- data_out_0_ready=0, requester 0 streaming, FIFO_DEPTH=4:
  - exactly 4 grants to requester 0, then data_in_0_ready stays 0;
  - requester 1 keeps full rate;
  - releasing ready drains 4 blocks in order and issue resumes.
- Push and pop on the same edge with the FIFO at 3/4:
  - occupancy stays 3;
  - no overflow and no lost block.
- Bench injects ex_valid_in with the tag pipeline empty:
  - err_sync=1 next cycle and stays 1;
  - no FIFO push;
  - a subsequent rst clears it.
- rst asserted mid-stream with 2 blocks in flight and FIFO 0 at 2 entries:
  - next cycle all valids=0, busy=0, FIFOs empty;
  - the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/mxint_exp_scheduler.sv
// rtl/mxint_exp_scheduler.sv - round-robin sharing of one fixed-latency mxint exp datapath between two requesters
module mxint_exp_scheduler #(
    parameter int DATA_IN_MAN_WIDTH  = 8,
    parameter int DATA_IN_EXP_WIDTH  = 3,
    parameter int DATA_OUT_MAN_WIDTH = 10,
    parameter int DATA_OUT_EXP_WIDTH = 4,
    parameter int BLOCK_SIZE         = 16,
    parameter int EXP_LATENCY        = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_IN_MAN_WIDTH*BLOCK_SIZE-1:0]    mdata_in_0,
    input  logic [DATA_IN_EXP_WIDTH-1:0]               edata_in_0,
    input  logic                                       data_in_0_valid,
    output logic                                       data_in_0_ready,
    input  logic [DATA_IN_MAN_WIDTH*BLOCK_SIZE-1:0]    mdata_in_1,
    input  logic [DATA_IN_EXP_WIDTH-1:0]               edata_in_1,
    input  logic                                       data_in_1_valid,
    output logic                                       data_in_1_ready,
    output logic [DATA_IN_MAN_WIDTH*BLOCK_SIZE-1:0]    ex_mdata_out,
    output logic [DATA_IN_EXP_WIDTH-1:0]               ex_edata_out,
    output logic                                       ex_valid_out,
    input  logic [DATA_OUT_MAN_WIDTH*BLOCK_SIZE-1:0]   ex_mdata_in,
    input  logic [DATA_OUT_EXP_WIDTH*BLOCK_SIZE-1:0]   ex_edata_in,
    input  logic                                       ex_valid_in,
    output logic [DATA_OUT_MAN_WIDTH*BLOCK_SIZE-1:0]   mdata_out_0,
    output logic [DATA_OUT_EXP_WIDTH*BLOCK_SIZE-1:0]   edata_out_0,
    output logic                                       data_out_0_valid,
    input  logic                                       data_out_0_ready,
    output logic [DATA_OUT_MAN_WIDTH*BLOCK_SIZE-1:0]   mdata_out_1,
    output logic [DATA_OUT_EXP_WIDTH*BLOCK_SIZE-1:0]   edata_out_1,
    output logic                                       data_out_1_valid,
    input  logic                                       data_out_1_ready,
    output logic                                       busy,
    output logic                                       err_sync
);

    localparam int MW = DATA_OUT_MAN_WIDTH * BLOCK_SIZE;
    localparam int EW = DATA_OUT_EXP_WIDTH * BLOCK_SIZE;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [CW-1:0] occ      [2];
    logic [CW-1:0] inflight [2];
    logic [PW-1:0] rd_ptr   [2];
    logic [PW-1:0] wr_ptr   [2];
    logic [MW-1:0] fifo_m   [2][FIFO_DEPTH];
    logic [EW-1:0] fifo_e   [2][FIFO_DEPTH];

    logic                   rr;
    logic [EXP_LATENCY-1:0] tag_v;
    logic [EXP_LATENCY-1:0] tag_id;
    logic                   err_q;

    logic [1:0] in_valid, out_ready, elig, grant, retire_k, push_k, pop_k, nonempty;
    logic       issue, gid, tail_v, tail_id, mismatch;
    logic [CW:0] used [2];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign in_valid  = {data_in_1_valid, data_in_0_valid};
    assign out_ready = {data_out_1_ready, data_out_0_ready};

    // Credit = FIFO_DEPTH - occupancy - in flight; eligible while credit remains.
    always_comb begin
        elig     = '0;
        nonempty = '0;
        for (int k = 0; k < 2; k++) begin
            used[k]     = {1'b0, occ[k]} + {1'b0, inflight[k]};
            elig[k]     = in_valid[k] && !rst && (used[k] < DEPTH_C);
            nonempty[k] = (occ[k] != '0);
        end
    end

    always_comb begin
        grant = elig;
        if (elig == 2'b11)
            grant = rr ? 2'b10 : 2'b01;
    end

    assign issue = |grant;
    assign gid   = grant[1];

    assign data_in_0_ready = grant[0];
    assign data_in_1_ready = grant[1];
    assign ex_valid_out    = issue;
    assign ex_mdata_out    = grant[1] ? mdata_in_1 : (grant[0] ? mdata_in_0 : '0);
    assign ex_edata_out    = grant[1] ? edata_in_1 : (grant[0] ? edata_in_0 : '0);

    // A tail slot retires even when its result is missing so credits never leak.
    assign tail_v   = tag_v[EXP_LATENCY-1];
    assign tail_id  = tag_id[EXP_LATENCY-1];
    assign mismatch = tail_v ^ ex_valid_in;
    assign retire_k = {tail_v & tail_id, tail_v & ~tail_id};
    assign push_k   = retire_k & {2{ex_valid_in}};
    assign pop_k    = nonempty & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr     <= 1'b0;
            tag_v  <= '0;
            tag_id <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                occ[k]      <= '0;
                inflight[k] <= '0;
                rd_ptr[k]   <= '0;
                wr_ptr[k]   <= '0;
            end
        end else begin
            if (issue)
                rr <= ~gid;
            tag_v[0]  <= issue;
            tag_id[0] <= gid;
            for (int i = 1; i < EXP_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (mismatch)
                err_q <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                occ[k]      <= occ[k] + CW'(push_k[k]) - CW'(pop_k[k]);
                inflight[k] <= inflight[k] + CW'(grant[k]) - CW'(retire_k[k]);
                if (push_k[k])
                    wr_ptr[k] <= nxt(wr_ptr[k]);
                if (pop_k[k])
                    rd_ptr[k] <= nxt(rd_ptr[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push_k[k] && !rst) begin
                fifo_m[k][wr_ptr[k]] <= ex_mdata_in;
                fifo_e[k][wr_ptr[k]] <= ex_edata_in;
            end
        end
    end

    assign mdata_out_0      = fifo_m[0][rd_ptr[0]];
    assign edata_out_0      = fifo_e[0][rd_ptr[0]];
    assign mdata_out_1      = fifo_m[1][rd_ptr[1]];
    assign edata_out_1      = fifo_e[1][rd_ptr[1]];
    assign data_out_0_valid = nonempty[0] && !rst;
    assign data_out_1_valid = nonempty[1] && !rst;

    assign busy     = !rst && ((inflight[0] != '0) || (inflight[1] != '0) || (|nonempty));
    assign err_sync = err_q && !rst;

endmodule
